seq_divider_16by8: RTL and testbench
====================================

Name: seq_divider_16by8

Overview:
- Sequential restoring divider: 16-bit unsigned dividend / 8-bit unsigned divisor -> 16-bit quotient + 8-bit remainder.
- Inverse companion to the 8x8 sequential shift-add multiplier; one quotient bit per clock via shift-subtract on a 9-bit partial remainder.
- Sits beside the multiplier in the arithmetic datapath; same start/done handshake so a controller can drive either unit.

Parameters:
- DIVIDEND_W, 16, dividend and quotient width; also the iteration count.
- DIVISOR_W, 8, divisor and remainder width; partial remainder is DIVISOR_W+1 bits.

Ports:
- clk  input  1  rising-edge clock
- reset_a  input  1  asynchronous active-high reset
- start  input  1  begin a division; sampled only in IDLE
- dividend  input  DIVIDEND_W  numerator, captured on accepted start
- divisor  input  DIVISOR_W  denominator, captured on accepted start
- quotient  output  DIVIDEND_W  result quotient, valid from done, held until next accepted start
- remainder  output  DIVISOR_W  result remainder, same validity as quotient
- busy  output  1  high from cycle after accepted start through the cycle done is high
- done  output  1  one-cycle pulse: results valid
- div_by_zero  output  1  set with done when divisor==0; cleared on next accepted start

Behaviour:
- Reset (async, any state): FSM->IDLE; quotient, remainder, busy, done, div_by_zero, internal registers, counter all 0. Reset mid-operation aborts; no done is produced.
- States: IDLE, CALC, FINISH.
- IDLE: start=1 -> capture dividend into Q shift reg, divisor into D, R<=0, cnt<=0, clear div_by_zero. divisor==0 -> FINISH; else -> CALC. start=0 -> stay.
- CALC, each cycle: Rs={R[DIVISOR_W-1:0], Q[MSB]}; T=Rs-{1'b0,D} (DIVISOR_W+1 bits, borrow = T MSB after extended subtract). No borrow -> R<=T, qbit=1; borrow -> R<=Rs, qbit=0. Q<={Q[MSB-1:0], qbit}; cnt++. After DIVIDEND_W iterations -> FINISH.
- Invariant: R < D before each shift, so R fits DIVISOR_W bits; 9-bit Rs never overflows.
- FINISH (one cycle): quotient<=Q, remainder<=R[DIVISOR_W-1:0]; done=1, busy=1 this cycle; -> IDLE.
- Divide by zero: quotient<=all ones (16'hFFFF), remainder<=dividend[7:0], div_by_zero=1, done in FINISH.
- Latency (normal): start in cycle 0 -> done high in cycle 17 (16 CALC + FINISH). Divide by zero: done in cycle 1.
- start while busy (CALC/FINISH): ignored; operands not recaptured.
- start in the IDLE cycle after FINISH: accepted; back-to-back throughput one op per 18 cycles.
- Outputs quotient/remainder change only in FINISH; held stable otherwise.

Optional Feature:
- Macro SEQ_DIV_EARLY_TERM_EN.
- Defined: in IDLE on accepted start, if divisor!=0 and dividend < {8'h00,divisor} -> skip CALC, go to FINISH with quotient=0, remainder=dividend[7:0]; done in cycle 1.
- Not defined: such cases run full 16 CALC cycles, same results, done in cycle 17. Divide-by-zero path unchanged either way.

Test Plan:
- dividend=1000, divisor=7, start one cycle -> done in cycle 17, quotient=142, remainder=6, div_by_zero=0, busy high cycles 1-17.
- 65535/255 -> quotient=257, remainder=0; 65535/1 -> quotient=65535, remainder=0; 255/16 -> quotient=15, remainder=15.
- dividend=5, divisor=0 -> done in cycle 1, div_by_zero=1, quotient=16'hFFFF, remainder=5; next valid start clears div_by_zero.
- dividend=3, divisor=10 -> quotient=0, remainder=3; done cycle 17 without macro, cycle 1 with SEQ_DIV_EARLY_TERM_EN.
- Start 1000/7, pulse start with 50/5 at cycle 6 -> ignored, result 142 r 6; start 50/5 after done -> 10 r 0.
- Start 1000/7, assert reset_a at cycle 8 -> all outputs 0 immediately, no done; after release new start 100/9 -> 11 r 1.

Source files
------------

// File: rtl/seq_divider_16by8.sv
// Sequential restoring divider, 16-bit dividend / 8-bit divisor, one quotient bit per clock.
// Optional macro SEQ_DIV_EARLY_TERM_EN: finish in one cycle when dividend < divisor.
module seq_divider_16by8 #(
  parameter int unsigned DIVIDEND_W = 16,
  parameter int unsigned DIVISOR_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset_a,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero
);

  localparam int unsigned CNT_W = $clog2(DIVIDEND_W + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DIVIDEND_W-1:0] r_q;
  logic [DIVISOR_W-1:0]  r_d;
  logic [DIVISOR_W-1:0]  r_r;
  logic [CNT_W-1:0]      r_cnt;
  logic [DIVIDEND_W-1:0] r_quotient;
  logic [DIVISOR_W-1:0]  r_remainder;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_dbz;

  logic [DIVISOR_W:0]    w_rs;
  logic [DIVISOR_W:0]    w_diff;
  logic                  w_borrow;
  logic [DIVISOR_W-1:0]  w_r_nxt;
  logic [DIVIDEND_W-1:0] w_q_nxt;
  logic                  w_last;
  logic                  w_accept;
  logic                  w_zero;
  logic                  w_early;

  // Shift-subtract step: the partial remainder stays below the divisor, so 9 bits suffice.
  assign w_rs     = {r_r, r_q[DIVIDEND_W-1]};
  assign w_diff   = w_rs - {1'b0, r_d};
  assign w_borrow = w_diff[DIVISOR_W];
  assign w_r_nxt  = w_borrow ? w_rs[DIVISOR_W-1:0] : w_diff[DIVISOR_W-1:0];
  assign w_q_nxt  = {r_q[DIVIDEND_W-2:0], ~w_borrow};
  assign w_last   = (r_cnt == CNT_W'(DIVIDEND_W - 1));
  assign w_accept = (r_state == S_IDLE) && start;
  assign w_zero   = (divisor == '0);

`ifdef SEQ_DIV_EARLY_TERM_EN
  assign w_early = !w_zero && (dividend < DIVIDEND_W'(divisor));
`else
  assign w_early = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (w_zero || w_early) ? S_FINISH : S_CALC;
        end
      end
      S_CALC: begin
        if (w_last) begin
          w_state_nxt = S_FINISH;
        end
      end
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered outputs; results load on entry to FINISH so they align with done
  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      r_q         <= '0;
      r_d         <= '0;
      r_r         <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= (w_state_nxt == S_FINISH);
      if (w_accept) begin
        r_q   <= dividend;
        r_d   <= divisor;
        r_r   <= '0;
        r_cnt <= '0;
        r_dbz <= w_zero;
        if (w_zero) begin
          r_quotient  <= '1;
          r_remainder <= dividend[DIVISOR_W-1:0];
        end else if (w_early) begin
          r_quotient  <= '0;
          r_remainder <= dividend[DIVISOR_W-1:0];
        end
      end else if (r_state == S_CALC) begin
        r_q   <= w_q_nxt;
        r_r   <= w_r_nxt;
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_quotient  <= w_q_nxt;
          r_remainder <= w_r_nxt;
        end
      end
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider_16by8.sv
// Self-checking bench for seq_divider_16by8: directed table, random ops vs arithmetic model, corner sequences.
module tb_seq_divider_16by8;

  logic        clk;
  logic        reset_a;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;
  logic [15:0] prev_q = '0;
  logic [7:0]  prev_r = '0;

  seq_divider_16by8 dut (
    .clk        (clk),
    .reset_a    (reset_a),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] eq;
    logic [7:0]  er;
    logic        edbz;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one op from an IDLE negedge; ign_at>0 pulses an ignored start (50/5) in that cycle.
  task automatic run_op(input logic [15:0] a, input logic [7:0] b, input string name, input int ign_at);
    logic [15:0] eq;
    logic [7:0]  er;
    logic        edbz;
    int          elat;
    int          n;
    edbz = (b == 8'd0);
    eq   = edbz ? 16'hFFFF : a / {8'd0, b};
    er   = edbz ? a[7:0] : 8'(a % {8'd0, b});
    elat = edbz ? 1 : 17;
`ifdef SEQ_DIV_EARLY_TERM_EN
    if (!edbz && a < {8'd0, b}) elat = 1;
`endif
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; dividend = ~a; divisor = ~b;
    n = 1;
    while (!done && n < 40) begin
      chk({name, " busy_mid"}, 32'(busy), 32'd1);
      chk({name, " q_held"}, 32'(quotient), 32'(prev_q));
      chk({name, " r_held"}, 32'(remainder), 32'(prev_r));
      if (n == ign_at) begin
        start = 1'b1; dividend = 16'd50; divisor = 8'd5;
      end else begin
        start = 1'b0; dividend = ~a; divisor = ~b;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: done not seen within 40 cycles, expected cycle %0d", name, elat);
    end else begin
      chk({name, " latency"}, 32'(n), 32'(elat));
      chk({name, " quotient"}, 32'(quotient), 32'(eq));
      chk({name, " remainder"}, 32'(remainder), 32'(er));
      chk({name, " dbz"}, 32'(div_by_zero), 32'(edbz));
      chk({name, " busy_done"}, 32'(busy), 32'd1);
    end
    @(negedge clk);
    chk({name, " done_pulse"}, 32'(done), 32'd0);
    chk({name, " busy_after"}, 32'(busy), 32'd0);
    chk({name, " q_after"}, 32'(quotient), 32'(eq));
    prev_q = eq;
    prev_r = er;
  endtask

  initial begin
    vec_t vecs[8];
    logic [15:0] ra;
    logic [7:0]  rb;

    vecs[0] = '{16'd1000,  8'd7,   16'd142,   8'd6,  1'b0};
    vecs[1] = '{16'd65535, 8'd255, 16'd257,   8'd0,  1'b0};
    vecs[2] = '{16'd65535, 8'd1,   16'd65535, 8'd0,  1'b0};
    vecs[3] = '{16'd255,   8'd16,  16'd15,    8'd15, 1'b0};
    vecs[4] = '{16'd5,     8'd0,   16'hFFFF,  8'd5,  1'b1};
    vecs[5] = '{16'd3,     8'd10,  16'd0,     8'd3,  1'b0};
    vecs[6] = '{16'd0,     8'd5,   16'd0,     8'd0,  1'b0};
    vecs[7] = '{16'd100,   8'd9,   16'd11,    8'd1,  1'b0};

    reset_a = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #1;
    chk("reset quotient", 32'(quotient), 32'd0);
    chk("reset remainder", 32'(remainder), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_a = 1'b0;
    @(negedge clk);

    // Table entries carry hand-derived results; cross-check against the model run
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, $sformatf("vec%0d", i), 0);
      chk($sformatf("vec%0d table_q", i), 32'(quotient), 32'(vecs[i].eq));
      chk($sformatf("vec%0d table_r", i), 32'(remainder), 32'(vecs[i].er));
      chk($sformatf("vec%0d table_dbz", i), 32'(div_by_zero), 32'(vecs[i].edbz));
    end

    // Divide by zero then a valid start clears the flag immediately
    run_op(16'd5, 8'd0, "dbz_set", 0);
    start = 1'b1; dividend = 16'd1000; divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    chk("dbz_cleared_on_start", 32'(div_by_zero), 32'd0);
    while (!done) @(negedge clk);
    chk("dbz_follow_q", 32'(quotient), 32'd142);
    @(negedge clk);
    prev_q = 16'd142; prev_r = 8'd6;

    // Start while busy is ignored; then back-to-back 50/5
    run_op(16'd1000, 8'd7, "ignore_start", 6);
    run_op(16'd50, 8'd5, "after_done", 0);

    // Reset mid-operation
    start = 1'b1; dividend = 16'd1000; divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset_a = 1'b1;
    #1;
    chk("abort quotient", 32'(quotient), 32'd0);
    chk("abort remainder", 32'(remainder), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    reset_a = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("abort no_done", 32'(done), 32'd0);
    end
    prev_q = '0; prev_r = '0;
    run_op(16'd100, 8'd9, "post_reset", 0);

    // Random operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      ra = (i % 4 == 0) ? 16'($urandom_range(0, 300)) : 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      run_op(ra, rb, $sformatf("rand%0d", i), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
